mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter attached to the computer's data-side store outputs (`memwrite`, `dataadr`, `writedata`), alongside `dmem`. Stores to the TX data address are captured into a small FIFO and serialized 8N1, LSB first, on `tx`. Stores to other addresses are ignored. The CPU therefore gets console output with no change to `cpu` or `dmem`.

---
 rtl/mmio_pkg.sv | 15 +
 rtl/mmio_uart_tx_if.sv | 13 +
 rtl/sync_fifo.sv | 76 +++++++
 rtl/mmio_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped peripherals hanging off the data-side store bus.
// Holds the UART transmitter state type and the default register addresses.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [15:0] UART_ADDR_DEFAULT = 16'hFF00;
  localparam logic [15:0] CTRL_ADDR_DEFAULT = 16'hFF02;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-side store bus as seen by MMIO peripherals: strobe, byte address and store data.
interface mmio_uart_tx_if #(
  parameter int n = 16
) ();

  logic         memwrite;
  logic [n-1:0] dataadr;
  logic [n-1:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read; a push is accepted when full
// only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    do_push_s = push && (!full || pop);
    do_pop_s  = pop && !empty;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (do_pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset discards contents by clearing pointers and storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX-address stores queue a byte, the FSM
// serializes queued bytes LSB first with gap-free back-to-back frames.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter int           n            = 16,
  parameter logic [n-1:0] UART_ADDR    = n'(UART_ADDR_DEFAULT),
  parameter logic [n-1:0] CTRL_ADDR    = n'(CTRL_ADDR_DEFAULT),
  parameter int           CLKS_PER_BIT = 4,
  parameter int           DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mmio_uart_tx_if.slave          bus,
  output logic                   tx,
  output logic                   tx_busy,
  output logic                   fifo_full,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  uart_state_t       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              overflow_q, overflow_d;

  logic              tx_store_s, ctrl_clr_s, push_s, pop_s, drop_s;
  logic              baud_end_s, fifo_empty_s;
  logic [7:0]        fifo_dout_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (bus.writedata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full),
    .empty (fifo_empty_s),
    .count (fifo_count)
  );

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign tx_busy  = (state_q != IDLE) || (fifo_count != '0);

  // Address decode and sticky overflow; a drop in the clearing cycle keeps the flag set.
  always_comb begin
    tx_store_s = bus.memwrite && (bus.dataadr == UART_ADDR);
    ctrl_clr_s = bus.memwrite && (bus.dataadr == CTRL_ADDR) && bus.writedata[0];
    push_s     = tx_store_s && (!fifo_full || pop_s);
    drop_s     = tx_store_s && fifo_full && !pop_s;
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ctrl_clr_s) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Frame sequencer: each state lasts one bit period of CLKS_PER_BIT cycles.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop_s      = 1'b0;
    baud_end_s = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          shift_d = fifo_dout_s;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (baud_end_s) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end_s) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end_s) begin
          baud_d = '0;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level follows the next state so tx can be a plain flop.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // Sequencer and flag registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed stores, a frame-decoding monitor against a byte
// scoreboard, plus cycle-exact status checks from the stimulus thread.
module tb_mmio_uart_tx;
  import mmio_pkg::*;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx, tx_busy, fifo_full, overflow;
  logic [3:0] fifo_count;

  mmio_uart_tx_if #(.n(16)) bus ();

  mmio_uart_tx #(
    .n            (16),
    .UART_ADDR    (16'hFF00),
    .CTRL_ADDR    (16'hFF02),
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int         total  = 0;
  int         bad    = 0;
  int         frames = 0;
  int         rst_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_byte;
  int         mon_rst;
  bit         mon_abort;
  logic [9:0] pat;

  always @(posedge clk) if (reset) rst_cnt <= rst_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    bus.memwrite  = 1'b1;
    bus.dataadr   = a;
    bus.writedata = d;
    @(negedge clk);
    bus.memwrite  = 1'b0;
  endtask

  // Monitor: decodes each frame from the line and pops the scoreboard at its end.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && tx === 1'b0) begin
        mon_rst   = rst_cnt;
        mon_abort = 1'b0;
        mon_byte  = 8'h00;
        for (int s = 1; s < 10*CPB; s++) begin
          @(negedge clk);
          if (rst_cnt != mon_rst) begin
            mon_abort = 1'b1;
            break;
          end
          if (s == CPB - 1) begin
            check("start_bit", {31'd0, tx}, 32'd0);
          end else if (s >= CPB + CPB/2 && s < 9*CPB && ((s - CPB/2) % CPB) == 0) begin
            mon_byte[3'((s - CPB/2)/CPB - 1)] = tx;
          end else if (s == 9*CPB + CPB/2 || s == 10*CPB - 1) begin
            check("stop_bit", {31'd0, tx}, 32'd1);
          end
        end
        if (!mon_abort) begin
          frames++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_byte: got %02h expected none", mon_byte);
          end else begin
            check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin : stim
    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.dataadr   = 16'h0000;
    bus.writedata = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_tx",       {31'd0, tx},        32'd1);
    check("rst_busy",     {31'd0, tx_busy},   32'd0);
    check("rst_full",     {31'd0, fifo_full}, 32'd0);
    check("rst_count",    {28'd0, fifo_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow},  32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx",       {31'd0, tx},        32'd1);
      check("idle_busy",     {31'd0, tx_busy},   32'd0);
      check("idle_count",    {28'd0, fifo_count}, 32'd0);
      check("idle_overflow", {31'd0, overflow},  32'd0);
    end

    // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop, four cycles each.
    exp_q.push_back(8'h55);
    store(16'hFF00, 16'h0055);
    check("push_tx",    {31'd0, tx},        32'd1);
    check("push_count", {28'd0, fifo_count}, 32'd1);
    check("push_busy",  {31'd0, tx_busy},   32'd1);
    @(negedge clk);
    check("pop_count", {28'd0, fifo_count}, 32'd0);
    pat = 10'b1_0101_0101_0;
    for (int c = 0; c < 40; c++) begin
      check("wave_55", {31'd0, tx}, {31'd0, pat[c/CPB]});
      if (c == 39) check("busy_last", {31'd0, tx_busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_fall", {31'd0, tx_busy}, 32'd0);
    check("end_tx",    {31'd0, tx},      32'd1);

    store(16'h0010, 16'h1234);
    check("other_count", {28'd0, fifo_count}, 32'd0);
    check("other_busy",  {31'd0, tx_busy},   32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("other_tx", {31'd0, tx}, 32'd1);
    end

    // Burst of ten stores at edges 1..10; 0x01 leaves at edge 2, so 0x0A is dropped.
    for (int i = 1; i <= 10; i++) begin
      if (i <= 9) exp_q.push_back(8'(i));
      store(16'hFF00, 16'(i));
    end
    check("burst_overflow", {31'd0, overflow},  32'd1);
    check("burst_full",     {31'd0, fifo_full}, 32'd1);
    check("burst_count",    {28'd0, fifo_count}, 32'd8);

    store(16'hFF02, 16'h0001);
    check("clr_overflow", {31'd0, overflow},  32'd0);
    check("clr_count",    {28'd0, fifo_count}, 32'd8);
    check("clr_full",     {31'd0, fifo_full}, 32'd1);

    // Store on edge 42, exactly when 0x02 is popped: accepted although full.
    repeat (30) @(negedge clk);
    check("pre_pp_count", {28'd0, fifo_count}, 32'd8);
    exp_q.push_back(8'h0B);
    store(16'hFF00, 16'h000B);
    check("pp_count",    {28'd0, fifo_count}, 32'd8);
    check("pp_overflow", {31'd0, overflow},  32'd0);
    check("pp_full",     {31'd0, fifo_full}, 32'd1);

    // Ten gap-free frames from edge 2 end at edge 402.
    repeat (359) @(negedge clk);
    check("burst_busy_hold", {31'd0, tx_busy}, 32'd1);
    @(negedge clk);
    check("burst_busy_fall", {31'd0, tx_busy},   32'd0);
    check("burst_end_count", {28'd0, fifo_count}, 32'd0);

    // Reset during DATA bit 3 of 0xFF, with a store presented in the reset cycle.
    repeat (3) @(negedge clk);
    store(16'hFF00, 16'h00FF);
    repeat (18) @(negedge clk);
    check("pre_reset_busy", {31'd0, tx_busy}, 32'd1);
    reset         = 1'b1;
    bus.memwrite  = 1'b1;
    bus.dataadr   = 16'hFF00;
    bus.writedata = 16'h00AA;
    @(negedge clk);
    reset        = 1'b0;
    bus.memwrite = 1'b0;
    check("mid_rst_tx",    {31'd0, tx},        32'd1);
    check("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    check("mid_rst_busy",  {31'd0, tx_busy},   32'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_tx",   {31'd0, tx},      32'd1);
      check("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    end

    check("frame_total", 32'(frames), 32'd11);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
